// File: rtl/reverb_cfg_pkg.sv
// Shared types and constants for the reverb configuration sequencer.
//   seq_state_e : sequencer FSM state encoding
//   FLUSH_LEN   : number of cycles the datapath is held disabled in FLUSH
//   FLUSH_CW    : width of the FLUSH down-counter
//   GAIN_W      : width of the feedback gain word (1.15 unsigned)
package reverb_cfg_pkg;

   typedef enum logic [2:0] {
      S_UNCONFIG  = 3'd0,
      S_RUN       = 3'd1,
      S_DRAIN     = 3'd2,
      S_FLUSH     = 3'd3,
      S_LOAD      = 3'd4,
      S_WAIT_DONE = 3'd5
   } seq_state_e;

   localparam int FLUSH_LEN = 2;
   localparam int FLUSH_CW  = (FLUSH_LEN > 1) ? $clog2(FLUSH_LEN) : 1;
   localparam int GAIN_W    = 16;

endpackage

// File: rtl/reverb_tap_ram.sv
// Tap storage: 2^G_ADDR_W x G_DATA_W, one write port, one registered read port.
// Ports:
//   clk      : clock
//   wr_en    : write strobe
//   wr_addr  : write index
//   wr_data  : write value
//   rd_addr  : read index, sampled every cycle
//   rd_data  : registered read data (one cycle after rd_addr)
// Contents are not reset.
module reverb_tap_ram #(
   parameter int G_ADDR_W = 4,
   parameter int G_DATA_W = 16
) (
   input  logic                clk,
   input  logic                wr_en,
   input  logic [G_ADDR_W-1:0] wr_addr,
   input  logic [G_DATA_W-1:0] wr_data,
   input  logic [G_ADDR_W-1:0] rd_addr,
   output logic [G_DATA_W-1:0] rd_data
);

   logic [G_DATA_W-1:0] mem_q [0:(1<<G_ADDR_W)-1];
   logic [G_DATA_W-1:0] rd_data_q, rd_data_d;

   // Write-first: a write to the index being read is visible on the next
   // cycle, so a host write to a not-yet-accepted tap reaches the stream.
   always_comb begin
      rd_data_d = mem_q[rd_addr];
      if (wr_en && (wr_addr == rd_addr)) begin
         rd_data_d = wr_data;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[wr_addr] <= wr_data;
      end
      rd_data_q <= rd_data_d;
   end

   assign rd_data = rd_data_q;

endmodule

// File: rtl/reverb_cfg_sequencer.sv
// Reverb configuration sequencer: drains the datapath, flushes it, streams
// the staged FIR taps and re-enables the datapath on each host commit.
// Build option: define REVERB_CFG_DOUBLE_BUFFER_EN for two tap banks (host
// writes the shadow bank, LOAD reads the active bank, swap on FLUSH entry).
// Ports:
//   clk, reset                      : clock, synchronous active-high reset
//   cfg_wr_en/addr/data             : host tap write
//   cfg_gain                        : host feedback gain (1.15 unsigned)
//   cfg_commit                      : apply staged taps and gain
//   cfg_busy, cfg_error             : host status
//   dp_enable, feedback_gain        : datapath control
//   up_valid -> dp_din_valid        : gated upstream valid
//   dp_din_ready, dp_dout_fire      : datapath handshakes (outstanding count)
//   tap_dout/_valid/_ready          : tap stream to the FIR
//   tap_done                        : FIR reports all taps loaded
//
// state     | meaning
// UNCONFIG  | no taps loaded, datapath off
// RUN       | datapath live, upstream valid passed through
// DRAIN     | input blocked, waiting for outstanding samples or timeout
// FLUSH     | datapath disabled for FLUSH_LEN cycles, gain latched
// LOAD      | streaming taps 0..N-1 to the FIR
// WAIT_DONE | waiting for FIR tap_done
module reverb_cfg_sequencer
   import reverb_cfg_pkg::*;
#(
   parameter int G_TAPS_LOG2     = 4,
   parameter int G_TAP_WIDTH     = 16,
   parameter int G_DRAIN_TIMEOUT = 1024
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   cfg_wr_en,
   input  logic [G_TAPS_LOG2-1:0] cfg_wr_addr,
   input  logic [G_TAP_WIDTH-1:0] cfg_wr_data,
   input  logic [GAIN_W-1:0]      cfg_gain,
   input  logic                   cfg_commit,
   output logic                   cfg_busy,
   output logic                   cfg_error,
   output logic                   dp_enable,
   output logic [GAIN_W-1:0]      feedback_gain,
   input  logic                   up_valid,
   output logic                   dp_din_valid,
   input  logic                   dp_din_ready,
   input  logic                   dp_dout_fire,
   output logic [G_TAP_WIDTH-1:0] tap_dout,
   output logic                   tap_dout_valid,
   input  logic                   tap_dout_ready,
   input  logic                   tap_done
);

   localparam int OUT_W = G_TAPS_LOG2 + 3;
   localparam int TMO_W = $clog2(G_DRAIN_TIMEOUT + 1);

   localparam logic [OUT_W-1:0]       OUT_MAX    = '1;
   localparam logic [G_TAPS_LOG2-1:0] IDX_LAST   = '1;
   localparam logic [TMO_W-1:0]       TMO_INIT   = TMO_W'(G_DRAIN_TIMEOUT - 1);
   localparam logic [FLUSH_CW-1:0]    FLUSH_INIT = FLUSH_CW'(FLUSH_LEN - 1);

   seq_state_e             state_q, state_d;
   logic [OUT_W-1:0]       outst_q, outst_d;
   logic [TMO_W-1:0]       tmo_q, tmo_d;
   logic [FLUSH_CW-1:0]    flush_q, flush_d;
   logic [G_TAPS_LOG2-1:0] idx_q, idx_d;
   logic [GAIN_W-1:0]      gain_q, gain_d;
   logic                   err_q, err_d;

   logic                   busy;
   logic                   enter_flush;
   logic                   din_fire;
   logic [G_TAPS_LOG2-1:0] rd_addr;
   logic [G_TAP_WIDTH-1:0] rd_data;

   always_comb begin
      state_d        = state_q;
      tmo_d          = tmo_q;
      flush_d        = flush_q;
      idx_d          = idx_q;
      gain_d         = gain_q;
      err_d          = err_q;
      busy           = 1'b1;
      enter_flush    = 1'b0;
      dp_enable      = 1'b0;
      dp_din_valid   = 1'b0;
      tap_dout_valid = 1'b0;
      rd_addr        = idx_q;

      case (state_q)
         S_UNCONFIG: begin
            busy = 1'b0;
            if (cfg_commit) begin
               state_d     = S_FLUSH;
               enter_flush = 1'b1;
            end
         end
         S_RUN: begin
            busy         = 1'b0;
            dp_enable    = 1'b1;
            dp_din_valid = up_valid;
            if (cfg_commit) begin
               state_d = S_DRAIN;
               tmo_d   = TMO_INIT;
            end
         end
         S_DRAIN: begin
            dp_enable = 1'b1;
            if (outst_q == '0) begin
               state_d     = S_FLUSH;
               enter_flush = 1'b1;
            end else if (tmo_q == '0) begin
               err_d       = 1'b1;
               state_d     = S_FLUSH;
               enter_flush = 1'b1;
            end else begin
               tmo_d = tmo_q - 1'b1;
            end
         end
         S_FLUSH: begin
            // Keep addressing tap 0 so its data is registered by LOAD entry.
            rd_addr = '0;
            idx_d   = '0;
            if (flush_q == FLUSH_INIT) begin
               gain_d = cfg_gain;
            end
            if (flush_q == '0) begin
               state_d = S_LOAD;
            end else begin
               flush_d = flush_q - 1'b1;
            end
         end
         S_LOAD: begin
            dp_enable      = 1'b1;
            tap_dout_valid = 1'b1;
            // Prefetch the next index on acceptance; otherwise re-read the
            // current one so the registered data tracks the held beat.
            if (tap_dout_ready) begin
               rd_addr = idx_q + 1'b1;
               idx_d   = idx_q + 1'b1;
               if (idx_q == IDX_LAST) begin
                  state_d = S_WAIT_DONE;
               end
            end
         end
         S_WAIT_DONE: begin
            dp_enable = 1'b1;
            if (tap_done) begin
               state_d = S_RUN;
            end
         end
         default: begin
            state_d = S_UNCONFIG;
         end
      endcase

      if (enter_flush) begin
         flush_d = FLUSH_INIT;
      end

      if (cfg_commit) begin
         err_d = busy ? 1'b1 : 1'b0;
      end
   end

   assign din_fire = dp_din_valid & dp_din_ready;

   always_comb begin
      outst_d = outst_q;
      if (din_fire && !dp_dout_fire && (outst_q != OUT_MAX)) begin
         outst_d = outst_q + 1'b1;
      end else if (!din_fire && dp_dout_fire && (outst_q != '0)) begin
         outst_d = outst_q - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_UNCONFIG;
         outst_q <= '0;
         tmo_q   <= '0;
         flush_q <= '0;
         idx_q   <= '0;
         gain_q  <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         outst_q <= outst_d;
         tmo_q   <= tmo_d;
         flush_q <= flush_d;
         idx_q   <= idx_d;
         gain_q  <= gain_d;
         err_q   <= err_d;
      end
   end

   assign cfg_busy      = busy;
   assign cfg_error     = err_q;
   assign feedback_gain = gain_q;
   assign tap_dout      = rd_data;

`ifdef REVERB_CFG_DOUBLE_BUFFER_EN
   logic                   bank_q, bank_d;
   logic                   wr_en0, wr_en1;
   logic [G_TAP_WIDTH-1:0] rd_data0, rd_data1;

   // bank_q names the active (read) bank; host writes the other one.
   always_comb begin
      bank_d = bank_q;
      if (enter_flush) begin
         bank_d = ~bank_q;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         bank_q <= 1'b0;
      end else begin
         bank_q <= bank_d;
      end
   end

   assign wr_en0  = cfg_wr_en &  bank_q;
   assign wr_en1  = cfg_wr_en & ~bank_q;
   assign rd_data = bank_q ? rd_data1 : rd_data0;

   reverb_tap_ram #(
      .G_ADDR_W (G_TAPS_LOG2),
      .G_DATA_W (G_TAP_WIDTH)
   ) u_tap_ram0 (
      .clk     (clk),
      .wr_en   (wr_en0),
      .wr_addr (cfg_wr_addr),
      .wr_data (cfg_wr_data),
      .rd_addr (rd_addr),
      .rd_data (rd_data0)
   );

   reverb_tap_ram #(
      .G_ADDR_W (G_TAPS_LOG2),
      .G_DATA_W (G_TAP_WIDTH)
   ) u_tap_ram1 (
      .clk     (clk),
      .wr_en   (wr_en1),
      .wr_addr (cfg_wr_addr),
      .wr_data (cfg_wr_data),
      .rd_addr (rd_addr),
      .rd_data (rd_data1)
   );
`else
   reverb_tap_ram #(
      .G_ADDR_W (G_TAPS_LOG2),
      .G_DATA_W (G_TAP_WIDTH)
   ) u_tap_ram (
      .clk     (clk),
      .wr_en   (cfg_wr_en),
      .wr_addr (cfg_wr_addr),
      .wr_data (cfg_wr_data),
      .rd_addr (rd_addr),
      .rd_data (rd_data)
   );
`endif

endmodule

// File: tb/tb_reverb_cfg_sequencer.sv
// Self-checking bench for reverb_cfg_sequencer (default single-bank build).
module tb_reverb_cfg_sequencer;

   localparam int TL2     = 4;
   localparam int N       = 16;
   localparam int TW      = 16;
   localparam int TMO     = 1024;
   localparam int OUT_MAX = 127;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          cfg_wr_en = 1'b0;
   logic [TL2-1:0] cfg_wr_addr = '0;
   logic [TW-1:0] cfg_wr_data = '0;
   logic [15:0]   cfg_gain = '0;
   logic          cfg_commit = 1'b0;
   logic          cfg_busy, cfg_error, dp_enable, dp_din_valid, tap_dout_valid;
   logic [15:0]   feedback_gain;
   logic          up_valid = 1'b0;
   logic          dp_din_ready = 1'b0;
   logic          dp_dout_fire = 1'b0;
   logic [TW-1:0] tap_dout;
   logic          tap_dout_ready = 1'b0;
   logic          tap_done = 1'b0;

   always #5 clk = ~clk;

   reverb_cfg_sequencer #(
      .G_TAPS_LOG2     (TL2),
      .G_TAP_WIDTH     (TW),
      .G_DRAIN_TIMEOUT (TMO)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .cfg_wr_en      (cfg_wr_en),
      .cfg_wr_addr    (cfg_wr_addr),
      .cfg_wr_data    (cfg_wr_data),
      .cfg_gain       (cfg_gain),
      .cfg_commit     (cfg_commit),
      .cfg_busy       (cfg_busy),
      .cfg_error      (cfg_error),
      .dp_enable      (dp_enable),
      .feedback_gain  (feedback_gain),
      .up_valid       (up_valid),
      .dp_din_valid   (dp_din_valid),
      .dp_din_ready   (dp_din_ready),
      .dp_dout_fire   (dp_dout_fire),
      .tap_dout       (tap_dout),
      .tap_dout_valid (tap_dout_valid),
      .tap_dout_ready (tap_dout_ready),
      .tap_done       (tap_done)
   );

   int          n_total = 0;
   int          n_bad   = 0;
   logic [TW-1:0] ref_taps [N];
   int          ref_outst = 0;
   logic [15:0] ref_gain  = '0;
   logic        ref_err   = 1'b0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_en"},    dp_enable, 0);
      check({tag, "_dinv"},  dp_din_valid, 0);
      check({tag, "_tapv"},  tap_dout_valid, 0);
      check({tag, "_busy"},  cfg_busy, 0);
      check({tag, "_err"},   cfg_error, 0);
      check({tag, "_gain"},  feedback_gain, 0);
   endtask

   task automatic write_tap(input int idx, input logic [TW-1:0] val);
      cfg_wr_en   = 1'b1;
      cfg_wr_addr = TL2'(idx);
      cfg_wr_data = val;
      tick();
      cfg_wr_en   = 1'b0;
      ref_taps[idx] = val;
   endtask

   task automatic commit_idle();
      cfg_gain   = 16'($urandom);
      ref_gain   = cfg_gain;
      cfg_commit = 1'b1;
      tick();
      cfg_commit = 1'b0;
      ref_err    = 1'b0;
      check("commit_err_clr", cfg_error, ref_err);
      check("commit_busy", cfg_busy, 1);
   endtask

   // Saturating outstanding-count model from handshakes seen at an edge.
   task automatic model_outst(input logic inc, input logic dec);
      int v;
      v = ref_outst + int'(inc) - int'(dec);
      if (v < 0) v = 0;
      if (v > OUT_MAX) v = OUT_MAX;
      ref_outst = v;
   endtask

   task automatic run_traffic(input int ncyc, input int fire_pct);
      logic inc;
      for (int c = 0; c < ncyc; c++) begin
         up_valid     = 1'($urandom_range(0, 1));
         dp_din_ready = 1'($urandom_range(0, 1));
         dp_dout_fire = ($urandom_range(0, 99) < fire_pct);
         settle();
         check("run_dinv", dp_din_valid, up_valid);
         check("run_en", dp_enable, 1);
         inc = up_valid & dp_din_ready;
         tick();
         model_outst(inc, dp_dout_fire);
      end
      up_valid = 1'b0;
      dp_dout_fire = 1'b0;
   endtask

   task automatic drain_fires();
      int n;
      up_valid     = 1'b1;
      dp_din_ready = 1'b1;
      while (ref_outst > 0) begin
         n = $urandom_range(0, 3);
         for (int g = 0; g < n; g++) begin
            settle();
            check("drain_en", dp_enable, 1);
            check("drain_dinv", dp_din_valid, 0);
            check("drain_busy", cfg_busy, 1);
            tick();
         end
         dp_dout_fire = 1'b1;
         settle();
         check("drain_fire_dinv", dp_din_valid, 0);
         check("drain_fire_en", dp_enable, 1);
         tick();
         dp_dout_fire = 1'b0;
         model_outst(1'b0, 1'b1);
      end
      n = 0;
      while (dp_enable && n < 4) begin
         tick();
         n++;
      end
      check("drain_exit", (n <= 2), 1);
      up_valid = 1'b0;
   endtask

   task automatic drain_timeout();
      int n = 0;
      dp_dout_fire = 1'b0;
      while (dp_enable && n < TMO + 100) begin
         if (n == TMO - 2) check("tmo_err_early", cfg_error, ref_err);
         tick();
         n++;
      end
      check("tmo_cycles", n, TMO);
      ref_err = 1'b1;
      check("tmo_err", cfg_error, ref_err);
   endtask

   // Expects the block in FLUSH (dp_enable low). Streams one load and checks
   // each accepted beat against the latest host value for that index.
   task automatic load_and_check(input int mode, input int commit_at, input int abort_at);
      int   flush = 0, k = 0, cyc = 0;
      logic prev_stall = 1'b0;
      logic [TW-1:0] prev_data = '0;
      logic [TW-1:0] nv;
      logic w1 = 1'b0, w2 = 1'b0;
      int   widx = -1;
      while (!dp_enable && flush < 20) begin
         flush++;
         tick();
      end
      check("flush_len", flush, 2);
      check("gain", feedback_gain, ref_gain);
      up_valid = 1'b1;
      while (k < N && cyc < 400) begin
         if (k == abort_at) begin
            reset = 1'b1;
            tap_dout_ready = 1'b1;
            tick();
            check_idle_outputs("abort");
            reset = 1'b0;
            ref_err = 1'b0; ref_gain = '0; ref_outst = 0;
            tick();
            check("abort_quiet", tap_dout_valid, 0);
            up_valid = 1'b0;
            return;
         end
         case (mode)
            0:       tap_dout_ready = 1'b1;
            1:       tap_dout_ready = (cyc % 2 == 0);
            default: tap_dout_ready = 1'($urandom_range(0, 1));
         endcase
         widx = -1;
         if (k == commit_at && !w1) begin
            cfg_commit = 1'b1;
            w1 = 1'b1;
            widx = N - 2;
         end else if (w1 && !w2 && k >= commit_at + 2) begin
            w2 = 1'b1;
            widx = 0;
         end
         if (widx >= 0) begin
            nv = 16'($urandom);
            cfg_wr_en = 1'b1;
            cfg_wr_addr = TL2'(widx);
            cfg_wr_data = nv;
         end
         settle();
         check("load_valid", tap_dout_valid, 1);
         check("load_dinv", dp_din_valid, 0);
         check("load_en", dp_enable, 1);
         if (prev_stall) check("stall_hold", tap_dout, prev_data);
         if (tap_dout_ready) begin
            check($sformatf("beat%0d", k), tap_dout, ref_taps[k]);
            k++;
         end
         prev_stall = !tap_dout_ready;
         prev_data  = tap_dout;
         if (widx >= 0) ref_taps[widx] = nv;
         if (cfg_commit) ref_err = 1'b1;
         tick();
         cfg_commit = 1'b0;
         cfg_wr_en  = 1'b0;
         cyc++;
      end
      check("beat_count", k, N);
      if (mode == 0) check("gapfree", cyc, N);
      check("wd_valid", tap_dout_valid, 0);
      check("wd_busy", cfg_busy, 1);
      check("load_err", cfg_error, ref_err);
      up_valid = 1'b0;
   endtask

   task automatic wait_done_to_run();
      int n;
      n = $urandom_range(0, 3);
      for (int g = 0; g < n; g++) begin
         settle();
         check("wd_hold_busy", cfg_busy, 1);
         tick();
      end
      tap_done = 1'b1;
      tick();
      tap_done = 1'b0;
      check("run_busy", cfg_busy, 0);
      check("run_en", dp_enable, 1);
      check("run_err", cfg_error, ref_err);
   endtask

   initial begin
      // reset state
      up_valid = 1'b1;
      reset = 1'b1;
      tick();
      tick();
      check_idle_outputs("reset");
      reset = 1'b0;
      up_valid = 1'b0;
      tick();
      check("unconfig_busy", cfg_busy, 0);

      // taps 0x0100+i, commit from UNCONFIG
      for (int i = 0; i < N; i++) write_tap(i, 16'h0100 + 16'(i));
      commit_idle();
      load_and_check(0, -1, -1);
      wait_done_to_run();

      // fires with nothing outstanding must not underflow; then 3 samples
      dp_dout_fire = 1'b1;
      tick();
      tick();
      dp_dout_fire = 1'b0;
      model_outst(1'b0, 1'b1);
      model_outst(1'b0, 1'b1);
      up_valid = 1'b1;
      dp_din_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         settle();
         check("in_dinv", dp_din_valid, 1);
         tick();
         model_outst(1'b1, 1'b0);
      end
      up_valid = 1'b0;
      check("outst3", ref_outst, 3);
      commit_idle();
      drain_fires();
      load_and_check(0, -1, -1);
      wait_done_to_run();

      // random taps, random traffic, ready toggling 1,0,1,0
      for (int i = 0; i < N; i++) write_tap(i, 16'($urandom));
      run_traffic(30, 30);
      commit_idle();
      drain_fires();
      load_and_check(1, -1, -1);
      wait_done_to_run();

      // saturate the outstanding count at its maximum
      up_valid = 1'b1;
      dp_din_ready = 1'b1;
      for (int i = 0; i < OUT_MAX + 15; i++) begin
         tick();
         model_outst(1'b1, 1'b0);
      end
      up_valid = 1'b0;
      commit_idle();
      drain_fires();
      load_and_check(2, -1, -1);
      wait_done_to_run();

      // drain timeout with no output fires
      up_valid = 1'b1;
      dp_din_ready = 1'b1;
      tick();
      model_outst(1'b1, 1'b0);
      up_valid = 1'b0;
      commit_idle();
      drain_timeout();
      load_and_check(2, -1, -1);
      wait_done_to_run();

      // idle commit clears the error; second commit during LOAD sets it
      commit_idle();
      drain_fires();
      load_and_check(0, 3, -1);
      wait_done_to_run();
      check("err_after_busy_commit", cfg_error, 1);

      // idle commit clears, then reset at LOAD beat 5
      commit_idle();
      drain_fires();
      load_and_check(0, -1, 5);
      commit_idle();
      load_and_check(2, -1, -1);
      wait_done_to_run();

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
